// File: rtl/scope_pkg.sv
// Shared scope definitions: default geometry of the capture/display RAMs,
// the signed sample type and the memcpy controller state encoding.
package scope_pkg;

    localparam int DEF_ADDR_W  = 9;
    localparam int DEF_NSAMP   = 500;
    localparam int DEF_PRETRIG = 250;
    localparam int SAMPLE_W    = 9;

    typedef logic signed [SAMPLE_W-1:0] sample_t;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COPY    = 2'd1,
        ST_DRAIN   = 2'd2,
        ST_RELEASE = 2'd3
    } memcpy_state_t;

endpackage

// File: rtl/display_memcpy_ctrl_if.sv
// Bundle between the memcpy controller and its surroundings: VGA window,
// acquisition handshake, capture RAM read port and display RAM write port.
interface display_memcpy_ctrl_if #(
    parameter int ADDR_W = scope_pkg::DEF_ADDR_W
);
    import scope_pkg::*;

    logic              memcpy_window;
    logic              capture_ready;
    logic              hold;
    logic [ADDR_W-1:0] trig_addr;
    sample_t           cap_rd_data_ch1;
    sample_t           cap_rd_data_ch2;

    logic              cap_rd_en;
    logic [ADDR_W-1:0] cap_rd_addr;
    logic              disp_wr_en;
    logic [ADDR_W-1:0] disp_wr_addr;
    sample_t           disp_wr_data_ch1;
    sample_t           disp_wr_data_ch2;
    logic              capture_release;
    logic              busy;
    logic [15:0]       copy_count;

    modport master (
        input  memcpy_window, capture_ready, hold, trig_addr,
               cap_rd_data_ch1, cap_rd_data_ch2,
        output cap_rd_en, cap_rd_addr, disp_wr_en, disp_wr_addr,
               disp_wr_data_ch1, disp_wr_data_ch2,
               capture_release, busy, copy_count
    );

    modport slave (
        output memcpy_window, capture_ready, hold, trig_addr,
               cap_rd_data_ch1, cap_rd_data_ch2,
        input  cap_rd_en, cap_rd_addr, disp_wr_en, disp_wr_addr,
               disp_wr_data_ch1, disp_wr_data_ch2,
               capture_release, busy, copy_count
    );

endinterface

// File: rtl/display_memcpy_ctrl.sv
// Once-per-frame copy of the triggered capture record into display RAM,
// started on the rising edge of the VGA memcpy window and aborted if it closes.
module display_memcpy_ctrl
    import scope_pkg::*;
#(
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int NSAMP   = DEF_NSAMP,
    parameter int PRETRIG = DEF_PRETRIG
) (
    input  logic                  vga_clk,
    input  logic                  reset,
    display_memcpy_ctrl_if.master bus
);

    localparam int CNT_W = $clog2(NSAMP + 1);

    memcpy_state_t     state_reg;
    logic              win_q;
    logic [CNT_W-1:0]  rd_cnt_reg;
    logic              cap_rd_en_reg;
    logic [ADDR_W-1:0] cap_rd_addr_reg;
    logic              disp_wr_en_reg;
    logic [ADDR_W-1:0] disp_wr_addr_reg;
    logic              capture_release_reg;
    logic              busy_reg;
    logic [15:0]       copy_count_reg;

    logic              start_next;
    logic              reads_done_next;
    logic [ADDR_W-1:0] start_addr_next;

    assign start_next      = bus.memcpy_window & ~win_q & bus.capture_ready & ~bus.hold;
    assign reads_done_next = (rd_cnt_reg == CNT_W'(NSAMP));
    assign start_addr_next = bus.trig_addr - ADDR_W'(PRETRIG);

    always_ff @(posedge vga_clk or posedge reset) begin
        if (reset) begin
            state_reg           <= ST_IDLE;
            win_q               <= 1'b0;
            rd_cnt_reg          <= '0;
            cap_rd_en_reg       <= 1'b0;
            cap_rd_addr_reg     <= '0;
            disp_wr_en_reg      <= 1'b0;
            disp_wr_addr_reg    <= '0;
            capture_release_reg <= 1'b0;
            busy_reg            <= 1'b0;
            copy_count_reg      <= '0;
        end else begin
            win_q <= bus.memcpy_window;
            case (state_reg)
                ST_IDLE: begin
                    disp_wr_en_reg      <= 1'b0;
                    capture_release_reg <= 1'b0;
                    if (start_next) begin
                        state_reg       <= ST_COPY;
                        cap_rd_addr_reg <= start_addr_next;
                        cap_rd_en_reg   <= 1'b1;
                        rd_cnt_reg      <= CNT_W'(1);
                        busy_reg        <= 1'b1;
                    end
                end
                ST_COPY: begin
                    // Window closed early: drop both strobes, keep the buffer for next frame.
                    if (!bus.memcpy_window && !reads_done_next) begin
                        state_reg      <= ST_IDLE;
                        cap_rd_en_reg  <= 1'b0;
                        disp_wr_en_reg <= 1'b0;
                        busy_reg       <= 1'b0;
                    end else begin
                        disp_wr_en_reg   <= cap_rd_en_reg;
                        disp_wr_addr_reg <= ADDR_W'(rd_cnt_reg - CNT_W'(1));
                        if (reads_done_next) begin
                            cap_rd_en_reg <= 1'b0;
                            state_reg     <= ST_DRAIN;
                        end else begin
                            cap_rd_addr_reg <= cap_rd_addr_reg + ADDR_W'(1);
                            rd_cnt_reg      <= rd_cnt_reg + CNT_W'(1);
                        end
                    end
                end
                ST_DRAIN: begin
                    disp_wr_en_reg      <= 1'b0;
                    busy_reg            <= 1'b0;
                    capture_release_reg <= 1'b1;
                    copy_count_reg      <= copy_count_reg + 16'd1;
                    state_reg           <= ST_RELEASE;
                end
                ST_RELEASE: begin
                    capture_release_reg <= 1'b0;
                    state_reg           <= ST_IDLE;
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.cap_rd_en       = cap_rd_en_reg;
    assign bus.cap_rd_addr     = cap_rd_addr_reg;
    assign bus.disp_wr_en      = disp_wr_en_reg;
    assign bus.disp_wr_addr    = disp_wr_addr_reg;
    assign bus.capture_release = capture_release_reg;
    assign bus.busy            = busy_reg;
    assign bus.copy_count      = copy_count_reg;

    // The capture RAM output register already sits one cycle behind the read,
    // aligned with the write strobe; gate it so idle write data reads as zero.
    assign bus.disp_wr_data_ch1 = disp_wr_en_reg ? bus.cap_rd_data_ch1 : '0;
    assign bus.disp_wr_data_ch2 = disp_wr_en_reg ? bus.cap_rd_data_ch2 : '0;

endmodule

// File: tb/tb_display_memcpy_ctrl.sv
// Directed bench for display_memcpy_ctrl: capture RAM holds a ramp, expected
// reads/writes are queued per copy and popped as the strobes appear.
module tb_display_memcpy_ctrl;
    import scope_pkg::*;

    localparam int AW = DEF_ADDR_W;
    localparam int NS = DEF_NSAMP;
    localparam int PT = DEF_PRETRIG;

    typedef struct packed {
        logic [AW-1:0] a;
        sample_t       d1;
        sample_t       d2;
    } wr_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    display_memcpy_ctrl_if #(.ADDR_W(AW)) bus ();

    display_memcpy_ctrl #(.ADDR_W(AW), .NSAMP(NS), .PRETRIG(PT)) dut (
        .vga_clk (clk),
        .reset   (reset),
        .bus     (bus.master)
    );

    sample_t ram1 [0:511];
    sample_t ram2 [0:511];

    always @(posedge clk) begin
        if (bus.cap_rd_en) begin
            bus.cap_rd_data_ch1 <= ram1[bus.cap_rd_addr];
            bus.cap_rd_data_ch2 <= ram2[bus.cap_rd_addr];
        end
    end

    logic [AW-1:0] rd_q [$];
    wr_t           wr_q [$];
    int checks = 0;
    int failures = 0;
    int nreads, nwrites, nrel, first_rd, first_wr, cyc;
    int exp_count = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic expect_copy(input int trig);
        for (int i = 0; i < NS; i++) begin
            int a;
            wr_t e;
            a = (trig - PT + i + 512) % 512;
            rd_q.push_back(AW'(a));
            e.a  = AW'(i);
            e.d1 = sample_t'(a);
            e.d2 = sample_t'(511 - a);
            wr_q.push_back(e);
        end
    endtask

    task automatic sample_outputs();
        cyc++;
        if (bus.cap_rd_en) begin
            nreads++;
            if (first_rd < 0) first_rd = cyc;
            if (rd_q.size() == 0) chk("rd_unexpected", 32'(nreads), 32'(0));
            else chk("rd_addr", 32'(bus.cap_rd_addr), 32'(rd_q.pop_front()));
        end
        if (bus.disp_wr_en) begin
            nwrites++;
            if (first_wr < 0) first_wr = cyc;
            if (wr_q.size() == 0) chk("wr_unexpected", 32'(nwrites), 32'(0));
            else begin
                wr_t e;
                e = wr_q.pop_front();
                chk("wr_addr", 32'(bus.disp_wr_addr), 32'(e.a));
                chk("wr_ch1", 32'(bus.disp_wr_data_ch1), 32'(e.d1));
                chk("wr_ch2", 32'(bus.disp_wr_data_ch2), 32'(e.d2));
            end
        end
        if (bus.capture_release) nrel++;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        sample_outputs();
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_rd_en"},   32'(bus.cap_rd_en),        32'(0));
        chk({tag, "_rd_addr"}, 32'(bus.cap_rd_addr),      32'(0));
        chk({tag, "_wr_en"},   32'(bus.disp_wr_en),       32'(0));
        chk({tag, "_wr_addr"}, 32'(bus.disp_wr_addr),     32'(0));
        chk({tag, "_wr_d1"},   32'(bus.disp_wr_data_ch1), 32'(0));
        chk({tag, "_wr_d2"},   32'(bus.disp_wr_data_ch2), 32'(0));
        chk({tag, "_release"}, 32'(bus.capture_release),  32'(0));
        chk({tag, "_busy"},    32'(bus.busy),             32'(0));
        chk({tag, "_count"},   32'(bus.copy_count),       32'(0));
    endtask

    // One VGA frame: window high for win_len edges, then idle until total.
    task automatic frame(input int win_len, input int total, input int rdy_at,
                         input int toggle_at, input int reset_at);
        bit rst_done = 0;
        bit rst_release = 0;
        nreads = 0; nwrites = 0; nrel = 0; first_rd = -1; first_wr = -1; cyc = 0;
        bus.memcpy_window = 1'b1;
        for (int c = 0; c < total; c++) begin
            if (c == win_len) bus.memcpy_window = 1'b0;
            if (c == rdy_at) bus.capture_ready = 1'b1;
            if (c == toggle_at) begin bus.capture_ready = 1'b0; bus.hold = 1'b1; end
            if (toggle_at >= 0 && c == toggle_at + 50) begin bus.capture_ready = 1'b1; bus.hold = 1'b0; end
            if (rst_release) begin reset = 1'b0; rst_release = 0; end
            step();
            if (reset_at >= 0 && !rst_done && nreads == reset_at) begin
                reset = 1'b1;
                bus.memcpy_window = 1'b0;
                rst_done = 1;
                rst_release = 1;
                #1;
                check_all_zero("async_rst");
                rd_q.delete();
                wr_q.delete();
                exp_count = 0;
            end
        end
    endtask

    task automatic end_checks(input string tag, input int er, input int ew, input int erel);
        chk({tag, "_reads"},    32'(nreads),  32'(er));
        chk({tag, "_writes"},   32'(nwrites), 32'(ew));
        chk({tag, "_releases"}, 32'(nrel),    32'(erel));
        chk({tag, "_count"},    32'(bus.copy_count), 32'(exp_count));
        chk({tag, "_busy_end"}, 32'(bus.busy), 32'(0));
        if (er > 0) chk({tag, "_latency"}, 32'(first_wr - first_rd), 32'(1));
    endtask

    initial begin
        for (int i = 0; i < 512; i++) begin
            ram1[i] = sample_t'(i);
            ram2[i] = sample_t'(511 - i);
        end
        bus.memcpy_window = 1'b0;
        bus.capture_ready = 1'b0;
        bus.hold          = 1'b0;
        bus.trig_addr     = '0;

        // Reset state
        reset = 1'b1;
        repeat (3) step();
        check_all_zero("reset");
        reset = 1'b0;
        repeat (5) step();

        // Basic copy, read window wraps 511 -> 0
        bus.trig_addr = AW'(300); bus.capture_ready = 1'b1;
        expect_copy(300); exp_count++;
        frame(NS, NS + 40, -1, -1, -1);
        end_checks("t300", NS, NS, 1);
        chk("t300_rdq_empty", 32'(rd_q.size()), 32'(0));
        chk("t300_wrq_empty", 32'(wr_q.size()), 32'(0));

        // Start address 272, wrap at read 240
        bus.trig_addr = AW'(10);
        expect_copy(10); exp_count++;
        frame(NS, NS + 40, -1, -1, -1);
        end_checks("t10", NS, NS, 1);
        chk("t10_wrq_empty", 32'(wr_q.size()), 32'(0));

        // hold blocks start; capture_ready low blocks start
        bus.hold = 1'b1;
        frame(NS, NS + 40, -1, -1, -1);
        end_checks("hold", 0, 0, 0);
        bus.hold = 1'b0; bus.capture_ready = 1'b0;
        frame(NS, NS + 40, -1, -1, -1);
        end_checks("notready", 0, 0, 0);

        // capture_ready rising mid-window waits for the next frame
        frame(NS, NS + 40, 10, -1, -1);
        end_checks("midready", 0, 0, 0);
        bus.trig_addr = AW'(123);
        expect_copy(123); exp_count++;
        frame(NS, NS + 40, -1, -1, -1);
        end_checks("nextwin", NS, NS, 1);

        // Short window aborts; next window retries from the start
        bus.trig_addr = AW'(400);
        expect_copy(400);
        frame(300, 340, -1, -1, -1);
        chk("abort_reads", 32'(nreads), 32'(300));
        chk("abort_releases", 32'(nrel), 32'(0));
        chk("abort_count", 32'(bus.copy_count), 32'(exp_count));
        chk("abort_writes_short", 32'(nwrites < NS), 32'(1));
        chk("abort_rd_en_low", 32'(bus.cap_rd_en), 32'(0));
        rd_q.delete(); wr_q.delete();
        expect_copy(400); exp_count++;
        frame(NS, NS + 40, -1, -1, -1);
        end_checks("retry", NS, NS, 1);

        // ready/hold toggled during COPY are ignored
        bus.trig_addr = AW'(77);
        expect_copy(77); exp_count++;
        frame(NS, NS + 40, -1, 100, -1);
        end_checks("toggle", NS, NS, 1);

        // Asynchronous reset at read 200, then a clean copy
        bus.trig_addr = AW'(200);
        expect_copy(200);
        frame(NS, NS + 40, -1, -1, 200);
        chk("rst_reads", 32'(nreads), 32'(200));
        chk("rst_releases", 32'(nrel), 32'(0));
        chk("rst_count", 32'(bus.copy_count), 32'(0));
        expect_copy(200); exp_count++;
        frame(NS, NS + 40, -1, -1, -1);
        end_checks("post_rst", NS, NS, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
